// File: rtl/tree_walk_ctrl_if.sv
// Bus bundle between the tree-walk controller and its environment
// (inference front-end, feature buffer and the synchronous node ROM).
//
// Handshake rules:
//   start     : request strobe, only looked at while the controller is idle.
//   done      : one-cycle completion strobe; class_out/error/depth_out are
//               valid with it and hold until the next done.
//   feat_req  : level request; it rises with feat_idx already stable, stays
//               high (feat_idx unchanged) through the cycle in which feat_ack
//               is sampled high, and drops on the following cycle. feat_data
//               is taken in the same cycle as feat_ack. feat_ack seen while
//               feat_req is low has no effect.
//   rom_addr  : registered address; rom_data answers one cycle later.
interface tree_walk_ctrl_if #(
    parameter int NODE_WIDTH = 120,
    parameter int ADDR_WIDTH = 10,
    parameter int FIDX_WIDTH = 4,
    parameter int FEAT_WIDTH = 64
);
    logic                  start;
    logic                  busy;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [NODE_WIDTH-1:0] rom_data;
    logic                  feat_req;
    logic [FIDX_WIDTH-1:0] feat_idx;
    logic                  feat_ack;
    logic [FEAT_WIDTH-1:0] feat_data;
    logic                  done;
    logic [3:0]            class_out;
    logic                  error;
    logic [5:0]            depth_out;

    // Controller side
    modport master (
        input  start, rom_data, feat_ack, feat_data,
        output busy, rom_addr, feat_req, feat_idx, done, class_out, error, depth_out
    );

    // Environment side
    modport slave (
        output start, rom_data, feat_ack, feat_data,
        input  busy, rom_addr, feat_req, feat_idx, done, class_out, error, depth_out
    );
endinterface

// File: rtl/tree_walk_ctrl.sv
// Decision-tree walk controller. Fetches nodes from a 1-cycle synchronous
// ROM starting at ROOT_ADDR, asks the feature buffer for the node's feature,
// compares it with the node threshold using the IEEE-754 total-order key and
// descends until a leaf, a depth overrun or an out-of-range child.
//
// Optional build macro: TREE_NODE_ID_CHECK_EN
//   defined   - each fetched node's id field must equal its ROM address,
//               otherwise the walk ends with error=1, class_out=4'hE.
//   undefined - the id field is ignored.
module tree_walk_ctrl #(
    parameter int NODE_WIDTH = 120,
    parameter int ADDR_WIDTH = 10,
    parameter int ROM_DEPTH  = 512,
    parameter int FIDX_WIDTH = 4,
    parameter int FEAT_WIDTH = 64,
    parameter int MAX_DEPTH  = 32,
    parameter int ROOT_ADDR  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    tree_walk_ctrl_if.master bus,
    output logic [2:0]       dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_WAIT    = 3'd2,
        S_DECODE  = 3'd3,
        S_FEAT    = 3'd4,
        S_COMPARE = 3'd5,
        S_DONE    = 3'd6
    } state_e;

    // Only the low node bits that carry fields are kept in the node register.
`ifdef TREE_NODE_ID_CHECK_EN
    localparam int NODE_KEEP = 108;
`else
    localparam int NODE_KEEP = 96;
`endif

    localparam logic [3:0] CLASS_ABORT  = 4'hF;
    localparam logic [3:0] CLASS_ID_BAD = 4'hE;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  rom_addr_q, rom_addr_d;
    logic [NODE_KEEP-1:0]   node_q, node_d;
    logic [FEAT_WIDTH-1:0]  feat_q, feat_d;
    logic [5:0]             depth_q, depth_d;
    logic                   feat_req_q, feat_req_d;
    logic [FIDX_WIDTH-1:0]  feat_idx_q, feat_idx_d;
    logic [3:0]             class_q, class_d;
    logic                   error_q, error_d;
    logic [5:0]             depth_out_q, depth_out_d;

    // Field views of the captured node
    logic [3:0]  node_fidx;
    logic [63:0] node_thr;
    logic [11:0] node_left;
    logic [11:0] node_right;
    logic [3:0]  node_tag;
    logic        node_is_leaf;
    logic        go_left;
    logic [11:0] child;
    logic        child_oob;
    logic        depth_full;

    assign node_fidx    = node_q[95:92];
    assign node_thr     = node_q[91:28];
    assign node_left    = node_q[27:16];
    assign node_right   = node_q[15:4];
    assign node_tag     = node_q[3:0];
    assign node_is_leaf = (node_left == 12'd0) && (node_right == 12'd0);
    assign depth_full   = (depth_q == 6'(MAX_DEPTH));

`ifdef TREE_NODE_ID_CHECK_EN
    logic [11:0] node_id;
    logic        id_bad;
    assign node_id = node_q[107:96];
    // rom_addr still points at the node being decoded
    assign id_bad  = (node_id != 12'(rom_addr_q));
`endif

    // ROM bits above the node fields carry nothing for this controller
    logic unused_rom_bits;
    assign unused_rom_bits = &{1'b0, bus.rom_data[NODE_WIDTH-1:NODE_KEEP]};

    // Map a double bit pattern to an unsigned key with the same ordering:
    // negatives are inverted, positives get the sign bit set, so -0.0 < +0.0.
    function automatic logic [FEAT_WIDTH-1:0] ord_key(input logic [FEAT_WIDTH-1:0] x);
        if (x[FEAT_WIDTH-1]) begin
            return ~x;
        end
        return x ^ {1'b1, {(FEAT_WIDTH-1){1'b0}}};
    endfunction

    // Child selection: ties go left
    always_comb begin
        go_left   = (ord_key(feat_q) <= ord_key(node_thr));
        child     = go_left ? node_left : node_right;
        child_oob = (32'(child) >= 32'(ROM_DEPTH));
    end

    // Next-state and register updates for the walk sequence
    always_comb begin
        state_d     = state_q;
        rom_addr_d  = rom_addr_q;
        node_d      = node_q;
        feat_d      = feat_q;
        depth_d     = depth_q;
        feat_req_d  = feat_req_q;
        feat_idx_d  = feat_idx_q;
        class_d     = class_q;
        error_d     = error_q;
        depth_out_d = depth_out_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    rom_addr_d = ADDR_WIDTH'(ROOT_ADDR);
                    depth_d    = 6'd0;
                    state_d    = S_FETCH;
                end
            end

            // ROM registers rom_addr at the end of this cycle
            S_FETCH: begin
                state_d = S_WAIT;
            end

            S_WAIT: begin
                node_d  = bus.rom_data[NODE_KEEP-1:0];
                state_d = S_DECODE;
            end

            S_DECODE: begin
`ifdef TREE_NODE_ID_CHECK_EN
                if (id_bad) begin
                    class_d     = CLASS_ID_BAD;
                    error_d     = 1'b1;
                    depth_out_d = depth_q;
                    state_d     = S_DONE;
                end else
`endif
                if (node_is_leaf) begin
                    class_d     = node_tag;
                    error_d     = 1'b0;
                    depth_out_d = depth_q;
                    state_d     = S_DONE;
                end else if (depth_full) begin
                    class_d     = CLASS_ABORT;
                    error_d     = 1'b1;
                    depth_out_d = depth_q;
                    state_d     = S_DONE;
                end else begin
                    feat_idx_d = FIDX_WIDTH'(node_fidx);
                    feat_req_d = 1'b1;
                    state_d    = S_FEAT;
                end
            end

            // Ack may arrive in the very first FEAT cycle
            S_FEAT: begin
                if (bus.feat_ack) begin
                    feat_d     = bus.feat_data;
                    feat_req_d = 1'b0;
                    state_d    = S_COMPARE;
                end
            end

            S_COMPARE: begin
                if (child_oob) begin
                    class_d     = CLASS_ABORT;
                    error_d     = 1'b1;
                    depth_out_d = depth_q;
                    state_d     = S_DONE;
                end else begin
                    rom_addr_d = child[ADDR_WIDTH-1:0];
                    depth_d    = depth_q + 6'd1;
                    state_d    = S_FETCH;
                end
            end

            // start is deliberately not looked at here
            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rom_addr_q  <= ADDR_WIDTH'(ROOT_ADDR);
            node_q      <= '0;
            feat_q      <= '0;
            depth_q     <= 6'd0;
            feat_req_q  <= 1'b0;
            feat_idx_q  <= '0;
            class_q     <= 4'd0;
            error_q     <= 1'b0;
            depth_out_q <= 6'd0;
        end else begin
            state_q     <= state_d;
            rom_addr_q  <= rom_addr_d;
            node_q      <= node_d;
            feat_q      <= feat_d;
            depth_q     <= depth_d;
            feat_req_q  <= feat_req_d;
            feat_idx_q  <= feat_idx_d;
            class_q     <= class_d;
            error_q     <= error_d;
            depth_out_q <= depth_out_d;
        end
    end

    assign bus.busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.rom_addr  = rom_addr_q;
    assign bus.feat_req  = feat_req_q;
    assign bus.feat_idx  = feat_idx_q;
    assign bus.class_out = class_q;
    assign bus.error     = error_q;
    assign bus.depth_out = depth_out_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_tree_walk_ctrl.sv
// Bench for tree_walk_ctrl: directed walks on a three-node tree followed by
// random trees, features and ack delays, all scored through an expected
// queue that a done-driven monitor drains.
module tb_tree_walk_ctrl;

    localparam int TB_MAX_DEPTH = 3;

    logic       clk;
    logic       rst_n;
    logic [2:0] dbg_state;

    tree_walk_ctrl_if #(.NODE_WIDTH(120), .ADDR_WIDTH(10), .FIDX_WIDTH(4), .FEAT_WIDTH(64)) bus ();

    tree_walk_ctrl #(
        .NODE_WIDTH(120), .ADDR_WIDTH(10), .ROM_DEPTH(512), .FIDX_WIDTH(4),
        .FEAT_WIDTH(64), .MAX_DEPTH(TB_MAX_DEPTH), .ROOT_ADDR(0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    typedef struct {
        logic [3:0] cls;
        logic       err;
        logic [5:0] dep;
        int         lat;   // latency before launch, absolute done cycle once queued
    } exp_t;

    localparam logic [63:0] D_ONE   = 64'h3FF0000000000000;
    localparam logic [63:0] D_TWO   = 64'h4000000000000000;
    localparam logic [63:0] D_THREE = 64'h4008000000000000;
    localparam logic [63:0] D_MHALF = 64'hBFE0000000000000;
    localparam logic [63:0] D_MONE  = 64'hBFF0000000000000;
    localparam logic [63:0] D_MZERO = 64'h8000000000000000;

    logic [119:0] mem [0:511];
    logic [63:0]  feats [0:15];
    exp_t         exp_q [$];
    int           cyc;
    int           n_checks;
    int           n_fail;
    int           ack_delay;
    logic         resp_ack;
    logic         stray_ack;
    int           rq_cnt;
    int           rq_first;
    logic [3:0]   rq_idx;
    bit           rq_chg;
    int           t_start;

    // ---------------- clock / reset / cycle count ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous 1-cycle ROM
    always @(posedge clk) bus.rom_data <= mem[bus.rom_addr];

    assign bus.feat_ack = resp_ack | stray_ack;

    // Feature buffer: answers feat_req after ack_delay waiting cycles
    initial begin
        int wcnt;
        wcnt = 0;
        resp_ack = 1'b0;
        bus.feat_data = '0;
        forever begin
            @(posedge clk);
            #1;
            if (resp_ack) begin
                resp_ack = 1'b0;
            end else if (bus.feat_req) begin
                if (wcnt >= ack_delay) begin
                    bus.feat_data = feats[bus.feat_idx];
                    resp_ack = 1'b1;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse pops one expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done in cycle %0d, required none", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("class_out", 64'(bus.class_out), 64'(e.cls));
                    chk("error", 64'(bus.error), 64'(e.err));
                    chk("depth_out", 64'(bus.depth_out), 64'(e.dep));
                    chk("done_cycle", 64'(cyc), 64'(e.lat));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [119:0] mk_node(input int id, input int fidx, input logic [63:0] thr,
                                             input int l, input int r, input int tag);
        return {12'h000, id[11:0], fidx[3:0], thr, l[11:0], r[11:0], tag[3:0]};
    endfunction

    // Numeric "feature <= threshold"; signed zeros ordered -0.0 < +0.0
    function automatic bit le(input logic [63:0] f, input logic [63:0] t);
        if (f[62:0] == 63'd0 && t[62:0] == 63'd0) begin
            return !(f[63] == 1'b0 && t[63] == 1'b1);
        end
        return $bitstoreal(f) <= $bitstoreal(t);
    endfunction

    // Walk the bench ROM as the tree is defined; latency from per-node costs
    function automatic exp_t model(input int d);
        exp_t e;
        int addr;
        int depth;
        logic [119:0] node;
        int l;
        int r;
        int child;
        addr = 0;
        depth = 0;
        e.cls = 4'hF; e.err = 1'b1; e.dep = 6'd0; e.lat = 0;
        for (int step = 0; step < 64; step++) begin
            node = mem[addr];
            l = int'(node[27:16]);
            r = int'(node[15:4]);
`ifdef TREE_NODE_ID_CHECK_EN
            if (int'(node[107:96]) != addr) begin
                e.cls = 4'hE; e.err = 1'b1; e.dep = 6'(depth); e.lat = 4 + depth * (5 + d);
                return e;
            end
`endif
            if (l == 0 && r == 0) begin
                e.cls = node[3:0]; e.err = 1'b0; e.dep = 6'(depth); e.lat = 4 + depth * (5 + d);
                return e;
            end
            if (depth == TB_MAX_DEPTH) begin
                e.cls = 4'hF; e.err = 1'b1; e.dep = 6'(depth); e.lat = 4 + depth * (5 + d);
                return e;
            end
            child = le(feats[node[95:92]], node[91:28]) ? l : r;
            if (child >= 512) begin
                e.cls = 4'hF; e.err = 1'b1; e.dep = 6'(depth); e.lat = 4 + depth * (5 + d) + d + 2;
                return e;
            end
            addr = child;
            depth++;
        end
        return e;
    endfunction

    function automatic logic [63:0] rand_dbl();
        case ($urandom_range(0, 9))
            0: return 64'h8000000000000000;
            1: return 64'h0000000000000000;
            default: return $realtobits(($itor($urandom_range(0, 200)) - 100.0) / 8.0);
        endcase
    endfunction

    function automatic int pick_child();
        int r;
        r = $urandom_range(0, 19);
        if (r == 0) return $urandom_range(512, 4095);
        if (r == 1) return 511;
        if (r == 2) return 0;
        return $urandom_range(1, 15);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic load_base(input logic [63:0] thr);
        for (int a = 0; a < 512; a++) mem[a] = mk_node(a, 0, 64'd0, 0, 0, a % 16);
        mem[0] = mk_node(0, 2, thr, 1, 2, 0);
        mem[1] = mk_node(1, 0, 64'd0, 0, 0, 1);
        mem[2] = mk_node(2, 0, 64'd0, 0, 0, 0);
    endtask

    task automatic build_random_rom();
        int id;
        for (int a = 0; a < 512; a++) mem[a] = mk_node(a, 0, 64'd0, 0, 0, a % 16);
        for (int a = 0; a < 16; a++) begin
            id = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 4095) : a;
            if (a != 0 && $urandom_range(0, 2) == 0)
                mem[a] = mk_node(id, 0, 64'd0, 0, 0, $urandom_range(0, 15));
            else
                mem[a] = mk_node(id, $urandom_range(0, 15), rand_dbl(), pick_child(), pick_child(),
                                 $urandom_range(0, 15));
        end
    endtask

    function automatic exp_t mk_exp(input logic [3:0] c, input logic e, input int dep, input int lat);
        exp_t x;
        x.cls = c; x.err = e; x.dep = 6'(dep); x.lat = lat;
        return x;
    endfunction

    // Called just after a rising edge: raise start and queue the expectation
    task automatic launch(input exp_t e);
        bus.start = 1'b1;
        t_start = cyc;
        e.lat = e.lat + cyc;
        exp_q.push_back(e);
    endtask

    // Run until the queue empties; optionally pulse start at cycle offset poke
    task automatic drain(input int poke);
        int n;
        n = 0;
        rq_cnt = 0; rq_first = -1; rq_idx = 4'd0; rq_chg = 1'b0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
            bus.start = (n == poke);
            if (bus.feat_req === 1'b1) begin
                if (rq_first < 0) begin
                    rq_first = cyc;
                    rq_idx = bus.feat_idx;
                end else if (bus.feat_idx !== rq_idx) begin
                    rq_chg = 1'b1;
                end
                rq_cnt++;
            end
        end
        bus.start = 1'b0;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending results, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic run_walk(input exp_t e);
        launch(e);
        drain(0);
    endtask

    // Second start held from the DONE cycle into the following idle cycle
    task automatic back_to_back(input exp_t e);
        exp_t e2;
        int n;
        launch(e);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            n++;
        end while (bus.done !== 1'b1 && n < 400);
        if (bus.done !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL b2b_wait: got no done within %0d cycles, required done", n);
            exp_q.delete();
        end else begin
            bus.start = 1'b1;
            e2 = e;
            e2.lat = e.lat + cyc + 1;
            exp_q.push_back(e2);
            @(posedge clk);
            #1;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        drain(0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n;
        exp_t e;
        n_checks = 0;
        n_fail = 0;
        ack_delay = 0;
        stray_ack = 1'b0;
        bus.start = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < 16; i++) feats[i] = 64'd0;
        load_base(D_TWO);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_feat_req", 64'(bus.feat_req), 64'd0);
        chk("rst_error", 64'(bus.error), 64'd0);
        chk("rst_rom_addr", 64'(bus.rom_addr), 64'd0);
        chk("rst_feat_idx", 64'(bus.feat_idx), 64'd0);
        chk("rst_class_out", 64'(bus.class_out), 64'd0);
        chk("rst_depth_out", 64'(bus.depth_out), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Test 1: 1.0 <= 2.0 goes left, zero-wait ack
        feats[2] = D_ONE;
        ack_delay = 0;
        run_walk(mk_exp(4'd1, 1'b0, 1, 9));
        chk("t1_req_cycle", 64'(rq_first), 64'(t_start + 4));
        chk("t1_feat_idx", 64'(rq_idx), 64'd2);
        chk("t1_req_len", 64'(rq_cnt), 64'd1);

        // Test 2: tie goes left, 3.0 goes right
        feats[2] = D_TWO;
        run_walk(mk_exp(4'd1, 1'b0, 1, 9));
        feats[2] = D_THREE;
        run_walk(mk_exp(4'd0, 1'b0, 1, 9));

        // Test 3: negative threshold, signed-zero ordering
        load_base(D_MHALF);
        feats[2] = D_MONE;
        run_walk(mk_exp(4'd1, 1'b0, 1, 9));
        feats[2] = D_MZERO;
        run_walk(mk_exp(4'd0, 1'b0, 1, 9));

        // Test 4: 3-cycle ack wait, stray start mid-walk
        load_base(D_TWO);
        feats[2] = D_ONE;
        ack_delay = 3;
        launch(mk_exp(4'd1, 1'b0, 1, 12));
        drain(6);
        chk("t4_req_len", 64'(rq_cnt), 64'd4);
        chk("t4_idx_stable", 64'(rq_chg), 64'd0);
        chk("t4_feat_idx", 64'(rq_idx), 64'd2);
        repeat (20) @(posedge clk);
        #1;

        // Stray ack while idle, then start held across DONE
        ack_delay = 0;
        stray_ack = 1'b1;
        @(posedge clk);
        #1;
        stray_ack = 1'b0;
        back_to_back(mk_exp(4'd1, 1'b0, 1, 9));

        // Test 5: depth overrun on a self loop, recovery, out-of-range child
        mem[0] = mk_node(0, 2, D_TWO, 1, 1, 0);
        mem[1] = mk_node(1, 2, D_TWO, 1, 1, 0);
        run_walk(mk_exp(4'hF, 1'b1, 3, 19));
        load_base(D_TWO);
        run_walk(mk_exp(4'd1, 1'b0, 1, 9));
        mem[0] = mk_node(0, 2, D_TWO, 600, 600, 0);
        run_walk(mk_exp(4'hF, 1'b1, 0, 6));

        // Test 6: reset while waiting for the feature
        load_base(D_TWO);
        ack_delay = 5;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n = 0;
        while (bus.feat_req !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t6_req_reached", 64'(bus.feat_req), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_feat_req", 64'(bus.feat_req), 64'd0);
        chk("t6_busy", 64'(bus.busy), 64'd0);
        chk("t6_done", 64'(bus.done), 64'd0);
        chk("t6_error", 64'(bus.error), 64'd0);
        chk("t6_class_out", 64'(bus.class_out), 64'd0);
        chk("t6_rom_addr", 64'(bus.rom_addr), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        ack_delay = 0;
        feats[2] = D_THREE;
        run_walk(mk_exp(4'd0, 1'b0, 1, 9));
`ifdef TREE_NODE_ID_CHECK_EN
        mem[1] = mk_node(5, 0, 64'd0, 0, 0, 1);
        feats[2] = D_ONE;
        run_walk(mk_exp(4'hE, 1'b1, 1, 9));
`endif

        // Random trees, features and ack delays against the model
        for (int w = 0; w < 30; w++) begin
            if (w % 6 == 0) build_random_rom();
            for (int i = 0; i < 16; i++) feats[i] = rand_dbl();
            ack_delay = $urandom_range(0, 3);
            if ($urandom_range(0, 4) == 0) begin
                stray_ack = 1'b1;
                @(posedge clk);
                #1;
                stray_ack = 1'b0;
            end
            e = model(ack_delay);
            if ($urandom_range(0, 3) == 0) back_to_back(e);
            else run_walk(e);
        end

        repeat (20) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tree_walk_ctrl.md
Name: tree_walk_ctrl

Overview:
- Sequencing controller for the decision-tree node ROM (sync 1-cycle read, 120-bit node words).
- On each inference request it walks the tree from the root to a leaf:
  - fetches the current node from the ROM,
  - requests the indexed feature value from the upstream feature buffer,
  - compares that value against the node threshold and selects a child,
  - returns the leaf class.
- Sits between the feature buffer / inference front-end and the tree ROM.

Parameters:
- NODE_WIDTH, 120, ROM word width
- ADDR_WIDTH, 10, ROM address width
- ROM_DEPTH, 512, valid node addresses 0..ROM_DEPTH-1
- FIDX_WIDTH, 4, feature index width
- FEAT_WIDTH, 64, feature/threshold width (IEEE-754 double bit pattern)
- MAX_DEPTH, 32, maximum nodes visited before abort
- ROOT_ADDR, 0, root node address

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  inference request; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until DONE
- rom_addr  out  ADDR_WIDTH  registered ROM address
- rom_data  in  NODE_WIDTH  ROM output; valid the cycle after rom_addr is sampled
- feat_req  out  1  feature request, level, held until ack
- feat_idx  out  FIDX_WIDTH  requested feature index, stable while feat_req=1
- feat_ack  in  1  feature return strobe
- feat_data  in  FEAT_WIDTH  feature value, valid with feat_ack
- done  out  1  one-cycle completion pulse
- class_out  out  4  leaf class; held until the next done
- error  out  1  set with done on abort; held until the next done
- depth_out  out  6  number of internal nodes traversed; held until the next done

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE
  - busy=0, done=0, feat_req=0, error=0
  - rom_addr=ROOT_ADDR, feat_idx=0, class_out=0, depth_out=0
- Node fields (low 108 bits of rom_data):
  - [107:96] node id
  - [95:92] feature index
  - [91:28] threshold
  - [27:16] left child
  - [15:4] right child
  - [3:0] tag
  - A node is a leaf when left=0 and right=0; class = tag.
- FSM states:
  - IDLE: on start=1 load rom_addr=ROOT_ADDR, clear depth → FETCH.
  - FETCH: ROM samples rom_addr → WAIT.
  - WAIT: capture rom_data into node register → DECODE.
  - DECODE:
    - leaf → DONE with class_out=tag.
    - Else, if depth=MAX_DEPTH → DONE with error=1, class_out=4'hF.
    - Else drive feat_idx=feature index, feat_req=1 → FEAT.
  - FEAT: hold feat_req until feat_ack=1; on ack capture feat_data, drop feat_req next cycle → COMPARE. feat_ack is accepted in the first FEAT cycle (zero-wait ack allowed).
  - COMPARE:
    - go left if key(feat) <= key(thr), else right.
    - If the selected child address >= ROM_DEPTH → DONE with error=1, class_out=4'hF.
    - Else rom_addr=child, depth+1 → FETCH.
  - DONE: done=1 for exactly one cycle, busy=0 → IDLE.
- Ordered key: if bit63=1 then key=~x, else key=x^(1<<63); compared as unsigned 64-bit.
  - -0.0 orders below +0.0.
  - NaN patterns are not checked.
- Latency:
  - start in cycle 0 → done in cycle 4 for a root leaf.
  - Each internal node adds 5 cycles plus feat_ack wait cycles.
- Boundary and corner cases:
  - start while busy: ignored.
  - feat_ack outside FEAT: ignored.
  - start in the DONE cycle: ignored; a new request is accepted from IDLE in the next cycle.
  - rst_n asserted mid-walk: immediate return to reset values, no done pulse.
  - The error flag is cleared when the next walk completes successfully.

Optional Feature:
- Macro: TREE_NODE_ID_CHECK_EN.
- Defined: in DECODE, if the node id field ≠ {zero-extended rom_addr} → DONE with error=1, class_out=4'hE, no feature request.
- Undefined: the node id field is ignored; no extra logic.

Test Plan:
- Bench ROM contents:
  - node0: feat 2, thr 0x4000000000000000 (2.0), L=1, R=2
  - node1: leaf class 1
  - node2: leaf class 0
- Test 1: start pulse in cycle 0, feature2=0x3FF0000000000000 (1.0), zero-wait ack → feat_idx=2 in cycle 4, done in cycle 9, class_out=1, depth_out=1, error=0.
- Test 2: feature2=0x4000000000000000 (tie) → left, class_out=1. feature2=0x4008000000000000 (3.0) → right, class_out=0.
- Test 3: change node0 thr to 0xBFE0000000000000 (-0.5).
  - feature2=0xBFF0000000000000 (-1.0) → class_out=1.
  - feature2=0x8000000000000000 (-0.0) → class_out=0.
- Test 4: 3-cycle ack delay → feat_req held high 4 cycles with feat_idx stable; done in cycle 12. A start pulse during the walk → no second done.
- Test 5: node0 L=R=1 self-loop chain with MAX_DEPTH=3 → done with error=1, class_out=F, depth_out=3. Child address 600 selected → done with error=1, class_out=F.
- Test 6: rst_n low during FEAT → feat_req=0, busy=0 immediately, no done. A subsequent start completes normally. With TREE_NODE_ID_CHECK_EN defined, a wrong node1 id → error=1, class_out=E.
